// File: rtl/event_unit_pkg.sv
// Event-unit shared constants: default sizing for the SoC peripheral event collector.
package event_unit_pkg;

  localparam int EU_NB_EVT_DFLT    = 8;
  localparam int EU_ID_WIDTH_DFLT  = 8;
  localparam int EU_CNT_WIDTH_DFLT = 8;
  // Wide enough to hold a per-cycle drop count for up to 256 sources.
  localparam int EU_DROP_CNT_W     = 9;

endpackage

// File: rtl/soc_evt_rr_arb.sv
// Round-robin arbiter: search starts one past the last granted index and wraps.
// Combinational grant; the pointer only moves on an enabled grant.
module soc_evt_rr_arb #(
  parameter int NB_REQ    = 8,
  parameter int IDX_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NB_REQ-1:0]    req_i,
  input  logic                 gnt_en_i,
  output logic [NB_REQ-1:0]    gnt_oh_o,
  output logic [IDX_WIDTH-1:0] gnt_idx_o
);

  localparam int PTR_W = $clog2(NB_REQ);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] win_idx;
  logic             found;

  always_comb begin
    int cand;
    found    = 1'b0;
    win_idx  = '0;
    gnt_oh_o = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NB_REQ) cand = cand - NB_REQ;
      if (!found && req_i[PTR_W'(cand)]) begin
        found   = 1'b1;
        win_idx = PTR_W'(cand);
      end
    end
    if (found && gnt_en_i) gnt_oh_o[win_idx] = 1'b1;
  end

  assign ptr_d     = (win_idx == PTR_W'(NB_REQ - 1)) ? '0 : win_idx + 1'b1;
  assign gnt_idx_o = IDX_WIDTH'(win_idx);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (gnt_en_i && found) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/soc_evt_collector.sv
// Collects per-source event strobes into pending bits and offers one ID per cycle to the event FIFO.
// One-cycle latency from pending to offer; the offer holds under fifo_fulln_i=0 and repeat events are counted as lost.
module soc_evt_collector
  import event_unit_pkg::*;
#(
  parameter int NB_EVT    = EU_NB_EVT_DFLT,
  parameter int ID_WIDTH  = EU_ID_WIDTH_DFLT,
  parameter int CNT_WIDTH = EU_CNT_WIDTH_DFLT
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NB_EVT-1:0]    evt_i,
  output logic                 fifo_data_valid_o,
  input  logic                 fifo_fulln_i,
  output logic [ID_WIDTH-1:0]  fifo_data_o,
  output logic                 lost_evt_o,
  output logic [CNT_WIDTH-1:0] lost_cnt_o,
  input  logic                 lost_clr_i
);

  localparam int SUM_W = CNT_WIDTH + EU_DROP_CNT_W;

  logic [NB_EVT-1:0]    pending_q, pending_d;
  logic                 valid_q, valid_d;
  logic [ID_WIDTH-1:0]  data_q, data_d;
  logic                 lost_evt_q, lost_evt_d;
  logic [CNT_WIDTH-1:0] lost_cnt_q, lost_cnt_d;

  logic                     push, free, gnt_en;
  logic [NB_EVT-1:0]        gnt_oh, drops;
  logic [ID_WIDTH-1:0]      gnt_idx;
  logic [EU_DROP_CNT_W-1:0] ndrop;
  logic [CNT_WIDTH-1:0]     cnt_base;
  logic [SUM_W-1:0]         cnt_sum;

  assign push   = valid_q & fifo_fulln_i;
  assign free   = ~valid_q | fifo_fulln_i;
  assign gnt_en = free & (|pending_q);

  soc_evt_rr_arb #(
    .NB_REQ    (NB_EVT),
    .IDX_WIDTH (ID_WIDTH)
  ) u_rr_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (pending_q),
    .gnt_en_i  (gnt_en),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx)
  );

  // A new strobe on a source whose bit is being granted this edge re-arms it rather than dropping.
  assign pending_d = (pending_q & ~gnt_oh) | evt_i;
  assign drops     = evt_i & pending_q & ~gnt_oh;

  always_comb begin
    ndrop = '0;
    for (int i = 0; i < NB_EVT; i++) begin
      ndrop = ndrop + EU_DROP_CNT_W'(drops[i]);
    end
  end

  // Clear takes effect first so drops on the clearing edge are still counted.
  assign cnt_base   = lost_clr_i ? '0 : lost_cnt_q;
  assign cnt_sum    = SUM_W'(cnt_base) + SUM_W'(ndrop);
  assign lost_cnt_d = (|cnt_sum[SUM_W-1:CNT_WIDTH]) ? '1 : cnt_sum[CNT_WIDTH-1:0];
  assign lost_evt_d = |drops;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (gnt_en) begin
      valid_d = 1'b1;
      data_d  = gnt_idx;
    end else if (push) begin
      valid_d = 1'b0;
      data_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q  <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      lost_evt_q <= 1'b0;
      lost_cnt_q <= '0;
    end else begin
      pending_q  <= pending_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      lost_evt_q <= lost_evt_d;
      lost_cnt_q <= lost_cnt_d;
    end
  end

  assign fifo_data_valid_o = valid_q;
  assign fifo_data_o       = data_q;
  assign lost_evt_o        = lost_evt_q;
  assign lost_cnt_o        = lost_cnt_q;

endmodule

// File: tb/tb_soc_evt_collector.sv
// Scoreboarded bench for soc_evt_collector: expected IDs are queued with stimulus and popped on each push.
module tb_soc_evt_collector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] evt = '0;
  logic       fulln = 1'b0;
  logic       clr = 1'b0;
  logic       vld;
  logic [7:0] data;
  logic       lost_evt;
  logic [7:0] lost_cnt;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int mon_e;

  always #5 clk = ~clk;

  soc_evt_collector #(
    .NB_EVT    (8),
    .ID_WIDTH  (8),
    .CNT_WIDTH (8)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .evt_i             (evt),
    .fifo_data_valid_o (vld),
    .fifo_fulln_i      (fulln),
    .fifo_data_o       (data),
    .lost_evt_o        (lost_evt),
    .lost_cnt_o        (lost_cnt),
    .lost_clr_i        (clr)
  );

  // Push monitor: every handshake must match the head of the expected-ID queue.
  always @(negedge clk) begin
    if (rst_n && vld && fulln) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL push_unexpected: got id %0d, required no push", data);
      end else begin
        mon_e = exp_q.pop_front();
        if (data !== 8'(mon_e)) begin
          errors++;
          $display("FAIL push_id: got %0d required %0d", data, mon_e);
        end
      end
    end else if (rst_n && !vld) begin
      checks++;
      if (data !== 8'd0) begin
        errors++;
        $display("FAIL data_zero_when_idle: got %0d required 0", data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    evt   = '0;
    clr   = 1'b0;
    fulln = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (vld !== 1'b0)      begin errors++; $display("FAIL reset_valid: got %b required 0", vld); end
    checks++; if (data !== 8'd0)     begin errors++; $display("FAIL reset_data: got %0d required 0", data); end
    checks++; if (lost_evt !== 1'b0) begin errors++; $display("FAIL reset_lost_evt: got %b required 0", lost_evt); end
    checks++; if (lost_cnt !== 8'd0) begin errors++; $display("FAIL reset_lost_cnt: got %0d required 0", lost_cnt); end
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got %b required 0", vld); end
  endtask

  task automatic test_single();
    do_reset();
    fulln = 1'b1;
    exp_q.push_back(2);
    evt = 8'h04;
    tick();
    evt = 8'h00;
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL single_latency: got valid %b required 0", vld); end
    tick();
    checks++; if (vld !== 1'b1 || data !== 8'd2) begin errors++; $display("FAIL single_offer: got v=%b id=%0d required v=1 id=2", vld, data); end
    tick();
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL single_drain: got valid %b required 0", vld); end
    repeat (4) tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_pushes: got %0d outstanding required 0", exp_q.size()); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    fulln = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(7);
    evt = 8'h81;
    tick();
    evt = 8'h00;
    tick();
    checks++; if (vld !== 1'b1 || data !== 8'd0) begin errors++; $display("FAIL simul_first: got v=%b id=%0d required v=1 id=0", vld, data); end
    tick();
    checks++; if (vld !== 1'b1 || data !== 8'd7) begin errors++; $display("FAIL simul_second: got v=%b id=%0d required v=1 id=7", vld, data); end
    repeat (4) tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL simul_pushes: got %0d outstanding required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    do_reset();
    exp_q.push_back(3);
    evt = 8'h08;
    tick();
    evt = 8'h00;
    tick();
    checks++; if (vld !== 1'b1 || data !== 8'd3) begin errors++; $display("FAIL bp_offer: got v=%b id=%0d required v=1 id=3", vld, data); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (vld !== 1'b1 || data !== 8'd3) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d got v=%b id=%0d required v=1 id=3", i, vld, data);
      end
    end
    fulln = 1'b1;
    tick();
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL bp_release: got valid %b required 0", vld); end
    repeat (5) tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_pushes: got %0d outstanding required 0", exp_q.size()); end
  endtask

  // ID 5 is first parked in the output register; the next three strobes then set pending once and drop twice.
  task automatic test_loss();
    do_reset();
    evt = 8'h20;
    tick();
    evt = 8'h00;
    tick();
    checks++; if (vld !== 1'b1 || data !== 8'd5) begin errors++; $display("FAIL loss_offer: got v=%b id=%0d required v=1 id=5", vld, data); end
    evt = 8'h20;
    repeat (3) tick();
    evt = 8'h00;
    checks++; if (lost_cnt !== 8'd2) begin errors++; $display("FAIL loss_cnt: got %0d required 2", lost_cnt); end
    checks++; if (lost_evt !== 1'b1) begin errors++; $display("FAIL loss_pulse: got %b required 1", lost_evt); end
    tick();
    checks++; if (lost_evt !== 1'b0) begin errors++; $display("FAIL loss_pulse_end: got %b required 0", lost_evt); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (lost_cnt !== 8'd0) begin errors++; $display("FAIL loss_clear: got %0d required 0", lost_cnt); end
    clr = 1'b1;
    evt = 8'h20;
    tick();
    clr = 1'b0;
    evt = 8'h00;
    checks++; if (lost_cnt !== 8'd1) begin errors++; $display("FAIL loss_clear_and_drop: got %0d required 1", lost_cnt); end
    checks++; if (vld !== 1'b1 || data !== 8'd5) begin errors++; $display("FAIL loss_held: got v=%b id=%0d required v=1 id=5", vld, data); end
    exp_q.push_back(5);
    exp_q.push_back(5);
    fulln = 1'b1;
    repeat (5) tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL loss_pushes: got %0d outstanding required 0", exp_q.size()); end
  endtask

  task automatic test_fairness();
    int exp_cnt;
    do_reset();
    fulln = 1'b1;
    for (int i = 0; i < 52; i++) exp_q.push_back(i % 8);
    evt = 8'hFF;
    for (int k = 1; k <= 45; k++) begin
      tick();
      exp_cnt = (k == 1) ? 0 : 7 * (k - 1);
      if (exp_cnt > 255) exp_cnt = 255;
      checks++;
      if (lost_cnt !== 8'(exp_cnt) || lost_evt !== (k >= 2)) begin
        errors++;
        $display("FAIL fair_lost: edge %0d got cnt=%0d evt=%b required cnt=%0d evt=%b", k, lost_cnt, lost_evt, exp_cnt, (k >= 2));
      end
      if (k >= 2) begin
        checks++;
        if (vld !== 1'b1) begin errors++; $display("FAIL fair_sustain: edge %0d got valid %b required 1", k, vld); end
      end
    end
    evt = 8'h00;
    repeat (12) tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fair_pushes: got %0d outstanding required 0", exp_q.size()); end
    checks++; if (lost_cnt !== 8'd255) begin errors++; $display("FAIL fair_saturate: got %0d required 255", lost_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    evt = 8'h08;
    tick();
    evt = 8'h10;
    tick();
    tick();
    evt = 8'h00;
    tick();
    checks++; if (vld !== 1'b1 || data !== 8'd3) begin errors++; $display("FAIL rst_stall_offer: got v=%b id=%0d required v=1 id=3", vld, data); end
    checks++; if (lost_cnt !== 8'd1) begin errors++; $display("FAIL rst_stall_cnt: got %0d required 1", lost_cnt); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (vld !== 1'b0)      begin errors++; $display("FAIL rst_stall_valid: got %b required 0", vld); end
    checks++; if (data !== 8'd0)     begin errors++; $display("FAIL rst_stall_data: got %0d required 0", data); end
    checks++; if (lost_evt !== 1'b0) begin errors++; $display("FAIL rst_stall_lost_evt: got %b required 0", lost_evt); end
    checks++; if (lost_cnt !== 8'd0) begin errors++; $display("FAIL rst_stall_lost_cnt: got %0d required 0", lost_cnt); end
    tick();
    rst_n = 1'b1;
    fulln = 1'b1;
    repeat (10) tick();
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL rst_stall_no_push: got valid %b required 0", vld); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rst_stall_queue: got %0d outstanding required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_loss();
    test_fairness();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/soc_evt_collector.md
SOC_EVT_COLLECTOR -- requirements
Module: soc_evt_collector

Interface
REQ-001: Parameter NB_EVT, default 8, number of SoC peripheral event sources (2..256).
REQ-002: Parameter ID_WIDTH, default 8, width of emitted event ID; NB_EVT SHALL be <= 2**ID_WIDTH.
REQ-003: Parameter CNT_WIDTH, default 8, width of lost-event counter.
REQ-004: clk_i  input  1  single clock, rising edge.
REQ-005: rst_ni  input  1  asynchronous, active-low reset.
REQ-006: evt_i  input  NB_EVT  per-source event strobe; each high cycle is one event.
REQ-007: fifo_data_valid_o  output  1  event ID offered to downstream event FIFO.
REQ-008: fifo_fulln_i  input  1  downstream has space; push = fifo_data_valid_o & fifo_fulln_i.
REQ-009: fifo_data_o  output  ID_WIDTH  offered event ID (source index, zero-extended).
REQ-010: lost_evt_o  output  1  single-cycle pulse when at least one event is dropped.
REQ-011: lost_cnt_o  output  CNT_WIDTH  saturating count of dropped events.
REQ-012: lost_clr_i  input  1  synchronous clear of lost_cnt_o.

Function
REQ-013: One pending bit per source; evt_i[k] high at an edge sets pending[k] at that edge.
REQ-014: Output is a one-entry register (valid + ID); "free" = not valid, or push this cycle.
REQ-015: When free and any pending bit set, round-robin arbiter SHALL load the winner's ID, set valid, and clear the winner's pending bit at the same edge.
REQ-016: Round-robin priority starts at (last granted index + 1) mod NB_EVT and wraps; after reset priority starts at index 0.
REQ-017: Latency: evt_i at edge n -> pending at n -> fifo_data_valid_o at n+1 if register free, with empty pending set otherwise.
REQ-018: While fifo_data_valid_o=1 and fifo_fulln_i=0, fifo_data_o SHALL hold stable and valid SHALL stay high.
REQ-019: Back-to-back pushes SHALL sustain one ID per cycle while fifo_fulln_i=1 and pending nonempty.
REQ-020: Event on source k whose pending bit is cleared by grant at the same edge SHALL re-set pending[k]; not a loss.
REQ-021: Event on source k with pending[k]=1 and not granted that edge SHALL be dropped.
REQ-022: Each edge with >=1 drop: lost_evt_o high next cycle; lost_cnt_o adds number of drops that edge, saturating at 2**CNT_WIDTH-1.
REQ-023: lost_clr_i at the same edge as drops SHALL clear then add that edge's drops.
REQ-024: fifo_data_o SHALL be 0 whenever fifo_data_valid_o=0.

Reset
REQ-025: On rst_ni low, asynchronously: pending=0, valid=0, fifo_data_o=0, lost_evt_o=0, lost_cnt_o=0, RR pointer=0.
REQ-026: Reset mid-handshake SHALL discard the offered ID and all pending events; no push after release until a new evt_i.

Structure
REQ-027: Default NB_EVT, ID_WIDTH and CNT_WIDTH constants SHALL live in event_unit_pkg next to existing event-unit constants.
REQ-028: Round-robin arbitration SHALL be sub-module soc_evt_rr_arb (req vector, grant enable, one-hot grant, encoded index, internal pointer).
REQ-029: Output drives soc_periph_fifo directly: fifo_data_valid_o->fifo_data_valid_i, fifo_fulln_i<-fifo_fulln_o, fifo_data_o->fifo_data_i.

Verification
REQ-030: Single event: evt_i=8'h04 one cycle, fulln=1 -> valid one cycle later, ID=2, one push, pending empty.
REQ-031: Simultaneous: evt_i=8'h81 one cycle after reset, fulln=1 -> pushes ID 0 then ID 7 on consecutive cycles.
REQ-032: Backpressure: fulln=0 for 5 cycles with ID 3 offered -> ID 3 held stable, pushed on first cycle fulln=1, no duplicate.
REQ-033: Fairness: evt_i=8'hFF every cycle, fulln=1 -> push order 0,1,...,7,0,... with no source starved; lost_cnt_o rises by 7 per cycle until saturating at 255.
REQ-034: Loss: fulln=0, evt_i[5] high 3 cycles -> ID 5 offered, lost_cnt_o=2 after; lost_clr_i -> 0.
REQ-035: Reset mid-stall: valid=1, fulln=0, assert rst_ni low -> all outputs 0 immediately; no push after release.
